pixel_capture: RTL and testbench
================================

PIXEL_CAPTURE -- requirements
Module: pixel_capture

Interface
REQ-001 SHALL provide parameters: DATA_W, default 12, ADC sample width; FIFO_DEPTH, default 16, output FIFO entries (power of two).
REQ-002 SHALL use one clock and a synchronous, active-low reset, as decided: i_clock  in  1  sole clock, all logic on rising edge.
REQ-003 i_rst_n  in  1  synchronous active-low reset.
REQ-004 i_enable  in  1  capture enable; low aborts any capture in progress and resets the sequence counter.
REQ-005 i_adc_frame  in  1  ADC frame strobe from the pixel timing generator; its rising edge starts a sample.
REQ-006 i_pixel_flag  in  1  pixel-valid flag from the timing generator, sampled at frame start.
REQ-007 i_adc_sdata  in  1  serial ADC data, MSB first, one bit per clock.
REQ-008 i_clear  in  1  synchronous flush of the FIFO and the sticky flags.
REQ-009 i_ready  in  1  downstream consumer ready.
REQ-010 o_data  out  16  FIFO head word {flag, seq[2:0], sample[11:0]}.
REQ-011 o_valid  out  1  FIFO non-empty.
REQ-012 o_count  out  5  FIFO occupancy, 0..16.
REQ-013 o_overflow  out  1  sticky: a word was dropped because the FIFO was full.
REQ-014 o_abort  out  1  sticky: a frame ended early.

Function
REQ-015 SHALL detect the i_adc_frame rising edge using a registered copy of the previous value.
REQ-016 SHALL implement the FSM IDLE -> SHIFT -> PUSH -> IDLE.
- IDLE: on rising edge with i_enable=1, go to SHIFT; capture bit 0 and latch i_pixel_flag in the same cycle.
REQ-017 In SHIFT, the block SHALL capture one bit per cycle while i_adc_frame=1; after DATA_W bits it SHALL go to PUSH.
REQ-018 If i_adc_frame falls before DATA_W bits are captured, the block SHALL discard the partial sample, set o_abort and return to IDLE.
REQ-019 In PUSH, the block SHALL write {flag, seq, sample} to the FIFO, increment seq (mod 8, wrapping 7->0) and return to IDLE.
REQ-020 Latency SHALL be: last data bit at cycle N, write at N+1, o_valid=1 at N+2; there is no empty-FIFO bypass.
REQ-021 Pop SHALL occur when o_valid && i_ready; o_data SHALL be the registered head and SHALL be stable while o_valid && !i_ready.
REQ-022 Write when full without a pop SHALL be dropped: o_overflow set, count unchanged.
REQ-023 Simultaneous push and pop when full SHALL accept both; count stays 16.
REQ-024 Simultaneous push and pop when empty SHALL store the word; the pop is ignored.
REQ-025 i_enable=0 SHALL force IDLE and set seq=0 without altering FIFO contents or flags.
REQ-026 i_clear=1 SHALL empty the FIFO and clear o_overflow and o_abort; this takes priority over a same-cycle push, which is dropped without setting o_overflow.
REQ-027 Read/write pointers SHALL be log2(FIFO_DEPTH) bits and wrap naturally.

Reset
REQ-028 While i_rst_n=0 at a clock edge, the block SHALL set state=IDLE, seq=0, FIFO pointers=0, o_valid=0, o_count=0, o_data=0, o_overflow=0, o_abort=0, shift register=0.
REQ-029 Reset mid-capture SHALL discard the partial sample with no flag set.

Configuration
REQ-030 Macro PIXEL_CAPTURE_PARITY_EN: when defined, SHIFT SHALL capture DATA_W+1 bits, the last being an even-parity bit over the sample.
- On mismatch: word discarded, sticky output o_parity_err (out, 1, reset 0, cleared by i_clear) set.
- On match: word pushed as normal.
REQ-031 Without PIXEL_CAPTURE_PARITY_EN: DATA_W bits only, no o_parity_err port.

Verification
REQ-032 Frame rise with flag=1 and bits 0xA5C MSB-first -> o_data=0x8A5C, o_valid high 2 cycles after last bit.
REQ-033 Frame held high 6 bits then dropped -> o_abort=1, o_count stays 0.
REQ-034 17 samples with i_ready=0 -> o_count=16, o_overflow=1; popping 16 returns seq 0..7,0..7 in order.
REQ-035 FIFO full, push and pop in the same cycle -> o_count=16, o_overflow stays 0.
REQ-036 i_rst_n low for 1 cycle mid-SHIFT, then a clean sample 0x123 -> only 0x0123 (flag 0, seq 0) emitted.
REQ-037 PARITY_EN: sample 0x001 with parity bit 0 -> dropped, o_parity_err=1; with parity bit 1 -> pushed.

Source files
------------

// File: rtl/pixel_capture.sv
// pixel_capture: samples a serial MSB-first ADC word per frame strobe and queues {flag, seq, sample}.
// Optional build macro PIXEL_CAPTURE_PARITY_EN adds a trailing even-parity bit and o_parity_err.
module pixel_capture #(
   parameter int DATA_W     = 12,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                        i_clock,
   input  logic                        i_rst_n,
   input  logic                        i_enable,
   input  logic                        i_adc_frame,
   input  logic                        i_pixel_flag,
   input  logic                        i_adc_sdata,
   input  logic                        i_clear,
   input  logic                        i_ready,
   output logic [DATA_W+3:0]           o_data,
   output logic                        o_valid,
   output logic [$clog2(FIFO_DEPTH):0] o_count,
   output logic                        o_overflow,
   output logic                        o_abort
`ifdef PIXEL_CAPTURE_PARITY_EN
  ,output logic                        o_parity_err
`endif
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int WORD_W = DATA_W + 4;
`ifdef PIXEL_CAPTURE_PARITY_EN
   localparam int NBITS  = DATA_W + 1;
`else
   localparam int NBITS  = DATA_W;
`endif
   localparam int BCNT_W = $clog2(NBITS + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, PUSH} state_t;

   state_t              state_q, state_d;
   logic                frame_prev_q, frame_prev_d;
   logic                frame_rise;
   logic [NBITS-1:0]    shift_q, shift_d;
   logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic                flag_q, flag_d;
   logic [2:0]          seq_q, seq_d;
   logic [DATA_W-1:0]   sample;
   logic [WORD_W-1:0]   word;
   logic                sample_done, abort_set, push_req;

   logic [WORD_W-1:0]   mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [WORD_W-1:0]   data_q, data_d;
   logic                overflow_q, overflow_d, abort_q, abort_d;
   logic                full, pop, wr_en, drop_full;

`ifdef PIXEL_CAPTURE_PARITY_EN
   logic                parity_ok, parity_err_q, parity_err_d;
   assign sample    = shift_q[NBITS-1:1];
   assign parity_ok = ~(^shift_q);
   assign push_req  = sample_done && parity_ok;
`else
   assign sample    = shift_q;
   assign push_req  = sample_done;
`endif

   assign frame_rise  = i_adc_frame && !frame_prev_q;
   assign sample_done = (state_q == PUSH) && i_enable;
   assign word        = {flag_q, seq_q, sample};

   always_comb begin
      state_d      = state_q;
      frame_prev_d = i_adc_frame;
      shift_d      = shift_q;
      bit_cnt_d    = bit_cnt_q;
      flag_d       = flag_q;
      seq_d        = seq_q;
      abort_set    = 1'b0;
      if (!i_enable) begin
         state_d = IDLE;
         seq_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (frame_rise) begin
                  state_d   = SHIFT;
                  shift_d   = {{(NBITS-1){1'b0}}, i_adc_sdata};
                  bit_cnt_d = BCNT_W'(1);
                  flag_d    = i_pixel_flag;
               end
            end
            SHIFT: begin
               if (i_adc_frame) begin
                  shift_d   = {shift_q[NBITS-2:0], i_adc_sdata};
                  bit_cnt_d = bit_cnt_q + BCNT_W'(1);
                  if (bit_cnt_q == BCNT_W'(NBITS - 1)) begin
                     state_d = PUSH;
                  end
               end else begin
                  abort_set = 1'b1;
                  state_d   = IDLE;
               end
            end
            PUSH: begin
               state_d = IDLE;
               seq_d   = seq_q + 3'd1;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // The head register always holds the next word to present, so o_data never
   // comes straight from the write path (no empty-FIFO bypass).
   assign pop       = (count_q != '0) && i_ready;
   assign full      = (count_q == CNT_W'(FIFO_DEPTH));
   assign wr_en     = push_req && !i_clear && (!full || pop);
   assign drop_full = push_req && !i_clear && full && !pop;
   assign rd_next   = rd_ptr_q + PTR_W'(1);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      data_d     = data_q;
      overflow_d = overflow_q | drop_full;
      abort_d    = abort_q | abort_set;
`ifdef PIXEL_CAPTURE_PARITY_EN
      parity_err_d = parity_err_q | (sample_done && !parity_ok);
`endif
      if (i_clear) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         data_d     = '0;
         overflow_d = 1'b0;
         abort_d    = 1'b0;
`ifdef PIXEL_CAPTURE_PARITY_EN
         parity_err_d = 1'b0;
`endif
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)   rd_ptr_d = rd_next;
         if (wr_en && !pop)      count_d = count_q + CNT_W'(1);
         else if (pop && !wr_en) count_d = count_q - CNT_W'(1);
         if (count_q == '0) begin
            if (wr_en) data_d = word;
         end else if (pop) begin
            if (count_q != CNT_W'(1)) data_d = mem_q[rd_next];
            else if (wr_en)           data_d = word;
         end
      end
   end

   // frame_prev loads the live strobe during reset so a frame still high after
   // reset is not mistaken for a new rising edge.
   always_ff @(posedge i_clock) begin
      if (!i_rst_n) begin
         state_q      <= IDLE;
         frame_prev_q <= i_adc_frame;
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         flag_q       <= 1'b0;
         seq_q        <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         data_q       <= '0;
         overflow_q   <= 1'b0;
         abort_q      <= 1'b0;
`ifdef PIXEL_CAPTURE_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         frame_prev_q <= frame_prev_d;
         shift_q      <= shift_d;
         bit_cnt_q    <= bit_cnt_d;
         flag_q       <= flag_d;
         seq_q        <= seq_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         data_q       <= data_d;
         overflow_q   <= overflow_d;
         abort_q      <= abort_d;
`ifdef PIXEL_CAPTURE_PARITY_EN
         parity_err_q <= parity_err_d;
`endif
      end
   end

   always_ff @(posedge i_clock) begin
      if (wr_en) mem_q[wr_ptr_q] <= word;
   end

   assign o_data     = data_q;
   assign o_valid    = (count_q != '0);
   assign o_count    = count_q;
   assign o_overflow = overflow_q;
   assign o_abort    = abort_q;
`ifdef PIXEL_CAPTURE_PARITY_EN
   assign o_parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_pixel_capture.sv
// tb_pixel_capture: directed stimulus with a queue scoreboard; a negedge monitor checks every popped word.
// Also builds with PIXEL_CAPTURE_PARITY_EN defined, adding the parity checks.
module tb_pixel_capture;

`ifdef PIXEL_CAPTURE_PARITY_EN
   localparam int NB = 13;
`else
   localparam int NB = 12;
`endif

   logic        i_clock = 1'b0;
   logic        i_rst_n, i_enable, i_adc_frame, i_pixel_flag, i_adc_sdata, i_clear, i_ready;
   logic [15:0] o_data;
   logic        o_valid, o_overflow, o_abort;
   logic [4:0]  o_count;
`ifdef PIXEL_CAPTURE_PARITY_EN
   logic        o_parity_err;
`endif

   int          vectors = 0;
   int          miscompares = 0;
   logic [15:0] exp_q[$];
   logic [15:0] exp_word;
   logic [2:0]  exp_seq = 3'd0;

   pixel_capture #(.DATA_W(12), .FIFO_DEPTH(16)) dut (
      .i_clock     (i_clock),
      .i_rst_n     (i_rst_n),
      .i_enable    (i_enable),
      .i_adc_frame (i_adc_frame),
      .i_pixel_flag(i_pixel_flag),
      .i_adc_sdata (i_adc_sdata),
      .i_clear     (i_clear),
      .i_ready     (i_ready),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .o_count     (o_count),
      .o_overflow  (o_overflow),
      .o_abort     (o_abort)
`ifdef PIXEL_CAPTURE_PARITY_EN
     ,.o_parity_err(o_parity_err)
`endif
   );

   always #5 i_clock = ~i_clock;

   task automatic tick();
      @(posedge i_clock);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
      end
   endtask

   // mode: 0 plain, 1 check push latency, 2 pop during the push cycle, 3 clear during the push cycle
   task automatic applyStimulus(input logic flag, input logic [11:0] sample, input bit exp_push,
                                input int mode, input bit par_flip);
      logic [NB-1:0] bits;
`ifdef PIXEL_CAPTURE_PARITY_EN
      bits = {sample, (^sample) ^ par_flip};
`else
      bits = sample;
      if (par_flip) $display("[TB] note: parity flip ignored without parity build");
`endif
      i_pixel_flag = flag;
      i_adc_frame  = 1'b1;
      for (int i = NB - 1; i >= 0; i--) begin
         i_adc_sdata = bits[i];
         tick();
      end
      i_adc_frame  = 1'b0;
      i_adc_sdata  = 1'b0;
      i_pixel_flag = 1'b0;
      if (exp_push) exp_q.push_back({flag, exp_seq, sample});
      exp_seq = exp_seq + 3'd1;
      if (mode == 1) checkOutput("valid_in_push_cycle", {31'd0, o_valid}, 32'd0);
      if (mode == 2) i_ready = 1'b1;
      if (mode == 3) begin
         i_clear = 1'b1;
         exp_q.delete();
      end
      tick();
      if (mode == 2) i_ready = 1'b0;
      if (mode == 3) i_clear = 1'b0;
      if (mode == 1) checkOutput("valid_two_after_last_bit", {31'd0, o_valid}, 32'd1);
   endtask

   always @(negedge i_clock) begin
      if (i_rst_n && o_valid && i_ready) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_pop: got %0h, required no word", o_data);
         end else begin
            exp_word = exp_q.pop_front();
            checkOutput("fifo_word", {16'd0, o_data}, {16'd0, exp_word});
         end
      end
   end

   initial begin
      i_rst_n = 1'b0; i_enable = 1'b1; i_adc_frame = 1'b0; i_pixel_flag = 1'b0;
      i_adc_sdata = 1'b0; i_clear = 1'b0; i_ready = 1'b0;
      tick(); tick();
      checkOutput("reset_valid",    {31'd0, o_valid},    32'd0);
      checkOutput("reset_count",    {27'd0, o_count},    32'd0);
      checkOutput("reset_data",     {16'd0, o_data},     32'd0);
      checkOutput("reset_overflow", {31'd0, o_overflow}, 32'd0);
      checkOutput("reset_abort",    {31'd0, o_abort},    32'd0);
      i_rst_n = 1'b1;
      tick();

      $display("[TB] basic capture 0xA5C with flag");
      i_ready = 1'b1;
      applyStimulus(1'b1, 12'hA5C, 1'b1, 1, 1'b0);
      tick();
      checkOutput("count_after_single_pop", {27'd0, o_count}, 32'd0);
      i_ready = 1'b0;

      $display("[TB] early frame drop");
      i_adc_frame = 1'b1;
      for (int i = 0; i < 6; i++) begin
         i_adc_sdata = i[0];
         tick();
      end
      i_adc_frame = 1'b0;
      tick();
      checkOutput("abort_set",      {31'd0, o_abort}, 32'd1);
      checkOutput("abort_no_word",  {27'd0, o_count}, 32'd0);
      i_enable = 1'b0;
      tick();
      i_enable = 1'b1;
      exp_seq  = 3'd0;
      checkOutput("abort_kept_by_enable_low", {31'd0, o_abort}, 32'd1);
      i_clear = 1'b1;
      tick();
      i_clear = 1'b0;
      checkOutput("abort_cleared", {31'd0, o_abort}, 32'd0);

      $display("[TB] overflow with 17 samples");
      for (int i = 0; i < 17; i++) begin
         applyStimulus(i[0], 12'(12'h30A + i * 241), (i < 16), 0, 1'b0);
      end
      checkOutput("count_full",    {27'd0, o_count},    32'd16);
      checkOutput("overflow_set",  {31'd0, o_overflow}, 32'd1);
      i_ready = 1'b1;
      repeat (18) tick();
      i_ready = 1'b0;
      checkOutput("count_drained",  {27'd0, o_count}, 32'd0);
      checkOutput("scoreboard_empty_1", exp_q.size(), 32'd0);
      i_clear = 1'b1;
      tick();
      i_clear = 1'b0;
      checkOutput("overflow_cleared", {31'd0, o_overflow}, 32'd0);

      $display("[TB] push and pop while full");
      for (int i = 0; i < 16; i++) begin
         applyStimulus(~i[1], 12'(12'hF0F ^ (i * 97)), 1'b1, 0, 1'b0);
      end
      applyStimulus(1'b1, 12'h5A5, 1'b1, 2, 1'b0);
      checkOutput("count_full_pushpop",    {27'd0, o_count},    32'd16);
      checkOutput("overflow_not_set",      {31'd0, o_overflow}, 32'd0);
      i_ready = 1'b1;
      repeat (18) tick();
      i_ready = 1'b0;
      checkOutput("scoreboard_empty_2", exp_q.size(), 32'd0);

      $display("[TB] clear beats same-cycle push");
      applyStimulus(1'b0, 12'h111, 1'b1, 0, 1'b0);
      applyStimulus(1'b1, 12'h222, 1'b1, 0, 1'b0);
      applyStimulus(1'b0, 12'h333, 1'b0, 3, 1'b0);
      checkOutput("clear_count",    {27'd0, o_count},    32'd0);
      checkOutput("clear_valid",    {31'd0, o_valid},    32'd0);
      checkOutput("clear_overflow", {31'd0, o_overflow}, 32'd0);

      $display("[TB] enable low mid-capture");
      i_adc_frame = 1'b1;
      repeat (4) tick();
      i_enable = 1'b0;
      tick();
      i_enable = 1'b1;
      exp_seq  = 3'd0;
      repeat (3) tick();
      i_adc_frame = 1'b0;
      tick();
      checkOutput("enable_abort_clear", {31'd0, o_abort}, 32'd0);
      checkOutput("enable_no_word",     {27'd0, o_count}, 32'd0);

      $display("[TB] reset mid-capture");
      i_ready = 1'b1;
      i_pixel_flag = 1'b1;
      i_adc_frame  = 1'b1;
      i_adc_sdata  = 1'b1;
      repeat (5) tick();
      i_rst_n = 1'b0;
      tick();
      i_rst_n = 1'b1;
      exp_q.delete();
      exp_seq = 3'd0;
      repeat (3) tick();
      i_adc_frame = 1'b0;
      tick();
      applyStimulus(1'b0, 12'h123, 1'b1, 1, 1'b0);
      tick();
      checkOutput("reset_midcap_count", {27'd0, o_count}, 32'd0);
      checkOutput("reset_midcap_abort", {31'd0, o_abort}, 32'd0);
      checkOutput("scoreboard_empty_3", exp_q.size(), 32'd0);
      i_ready = 1'b0;

`ifdef PIXEL_CAPTURE_PARITY_EN
      $display("[TB] parity check");
      applyStimulus(1'b0, 12'h001, 1'b0, 0, 1'b1);
      checkOutput("parity_err_set",  {31'd0, o_parity_err}, 32'd1);
      checkOutput("parity_dropped",  {27'd0, o_count},      32'd0);
      applyStimulus(1'b0, 12'h001, 1'b1, 0, 1'b0);
      checkOutput("parity_pushed",   {27'd0, o_count},      32'd1);
      i_ready = 1'b1;
      repeat (3) tick();
      i_ready = 1'b0;
      i_clear = 1'b1;
      tick();
      i_clear = 1'b0;
      checkOutput("parity_err_cleared", {31'd0, o_parity_err}, 32'd0);
`endif

      tick();
      checkOutput("scoreboard_final_empty", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
